// File: rtl/load_extend_pkg.sv
// Shared constants for the load-extend unit: request mode codes and FSM state encoding.
package load_extend_pkg;

  localparam logic [1:0] MODE_ZEXT_B = 2'b00;
  localparam logic [1:0] MODE_SEXT_B = 2'b01;
  localparam logic [1:0] MODE_WORD   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

endpackage

// File: rtl/load_extend_unit_byte_extender.sv
// Combinational widener: zero- or sign-extends a narrow value to OUT_WIDTH bits.
module byte_extender #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  i_data,
  input  logic                 i_sign_en,
  output logic [OUT_WIDTH-1:0] o_data
);

  logic w_fill;

  assign w_fill = i_sign_en & i_data[IN_WIDTH-1];
  assign o_data = {{(OUT_WIDTH-IN_WIDTH){w_fill}}, i_data};

endmodule

// File: rtl/load_extend_unit.sv
// Load-data formatter: collects memory beats little-endian into a word, or extends a
// single byte, and presents the result with a one-cycle valid pulse.
module load_extend_unit
  import load_extend_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [1:0]            req_mode,
  output logic                  req_ready,
  input  logic                  mem_valid,
  input  logic [BUS_WIDTH-1:0]  mem_data,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / BUS_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [1:0]            r_state;
  logic [1:0]            r_mode;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [DATA_WIDTH-1:0] r_result;

  logic [DATA_WIDTH-1:0] w_asm;
  logic [DATA_WIDTH-1:0] w_ext;
  logic [DATA_WIDTH-1:0] w_format;
  logic                  w_last;
  logic                  w_word;

  // Assembly register with the incoming beat merged into the current slot, so the
  // final beat can go straight into the result on the same edge.
  always_comb begin
    w_asm = r_asm;
    for (int b = 0; b < BEATS; b++) begin
      if (r_cnt == CNT_W'(b)) begin
        w_asm[b*BUS_WIDTH +: BUS_WIDTH] = mem_data;
      end
    end
  end

  byte_extender #(
    .IN_WIDTH  (BUS_WIDTH),
    .OUT_WIDTH (DATA_WIDTH)
  ) u_byte_extender (
    .i_data    (mem_data),
    .i_sign_en (r_mode == MODE_SEXT_B),
    .o_data    (w_ext)
  );

  assign w_word   = (r_mode == MODE_WORD);
  assign w_last   = w_word ? (r_cnt == CNT_W'(BEATS-1)) : 1'b1;
  assign w_format = w_word ? w_asm : w_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mode   <= MODE_ZEXT_B;
      r_cnt    <= '0;
      r_asm    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_mode  <= req_mode;
            r_cnt   <= '0;
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (mem_valid) begin
            r_asm <= w_asm;
            if (w_last) begin
              r_result <= w_format;
              r_cnt    <= '0;
              r_state  <= DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == DONE);
  assign result       = r_result;

endmodule

// File: doc/load_extend_unit.md
Name: load_extend_unit

Overview:
- Sequential load-data formatter between data memory and the register-file write port.
- Collects one or more narrow memory beats and assembles them little-endian into a full word.
- Byte loads are zero- or sign-extended to full register width, selected per request.
- Replaces the fixed 8-to-16 combinational zero extender; adds sign extension, multi-beat word assembly and a request/result handshake.

Parameters:
- DATA_WIDTH, 16, width of the assembled/extended result (register width).
- BUS_WIDTH, 8, width of one memory beat. DATA_WIDTH must be an integer multiple of BUS_WIDTH, at least 2 beats.
- BEATS (localparam), DATA_WIDTH/BUS_WIDTH, beats per full-word load.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_mode  in  2  00 = zero-extend byte, 01 = sign-extend byte, 10 = full word, 11 = reserved (treated as 00).
- req_ready  out  1  unit can accept a request.
- mem_valid  in  1  mem_data holds a valid beat this cycle.
- mem_data  in  BUS_WIDTH  memory beat.
- result  out  DATA_WIDTH  formatted load value; held until the next result.
- result_valid  out  1  one-cycle pulse marking a new result.
- busy  out  1  high in COLLECT and DONE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. On rst, immediately and regardless of the clock:
  - state = IDLE;
  - result, assembly register and beat counter = 0;
  - result_valid = 0, busy = 0, req_ready = 1 (follows state).
- IDLE:
  - req_ready = 1.
  - A clock edge with req_valid = 1 latches req_mode, clears the beat counter and moves to COLLECT.
  - mem_valid is ignored in IDLE.
- COLLECT:
  - req_ready = 0; req_valid is ignored.
  - Each edge with mem_valid = 1 writes mem_data into assembly slot [cnt*BUS_WIDTH +: BUS_WIDTH] and increments cnt.
  - mem_valid = 0 stalls the unit with no state change. Gaps of any length are allowed.
  - The final beat is beat 0 in byte modes and beat BEATS-1 in full-word mode.
  - On the final-beat edge, result is loaded and state goes to DONE.
- Result formatting:
  - Zero-extend byte: upper DATA_WIDTH-BUS_WIDTH bits are 0.
  - Sign-extend byte: upper bits replicate mem_data[BUS_WIDTH-1].
  - Full word: the assembled value with the final beat in the top slot, no extension.
- DONE:
  - Lasts exactly one cycle: result_valid = 1, busy = 1, req_ready = 0.
  - The next edge returns to IDLE unconditionally.
  - mem_valid is ignored in DONE.
- Latency: result_valid rises in the cycle after the final beat is sampled. Minimum request-to-result time is 2 edges for byte modes and BEATS+1 edges for full word.
- Throughput: a new request is accepted at the earliest in the cycle after DONE.
- Boundary conditions:
  - Beats arriving before a request are dropped.
  - Extra beats after the final beat are dropped.
  - The counter never exceeds BEATS-1.
  - Reset mid-COLLECT discards the partial word and emits no result_valid.
  - req_valid held high across DONE is accepted in the following IDLE cycle.
  - Reserved mode behaves as zero-extend byte.

Decomposition:
- Shared package load_extend_pkg:
  - mode constants MODE_ZEXT_B, MODE_SEXT_B, MODE_WORD, MODE_RSVD;
  - state encoding IDLE / COLLECT / DONE.
- One combinational sub-module, byte_extender, parametrised by IN_WIDTH and OUT_WIDTH with a sign_en input. It performs the byte-mode extension.
- The FSM, counter and assembly register stay in load_extend_unit.

Test Plan:
- Defaults, reset, then mode 00 and beat 0xF0 -> result 0x00F0; result_valid one-cycle pulse the cycle after the beat; busy drops the cycle after.
- Mode 01 with beat 0x98 -> 0xFF98. Mode 01 with beat 0x21 -> 0x0021. Mode 11 with beat 0x98 -> 0x0098.
- Mode 10 with beats 0x34, two idle cycles, then 0x12 -> 0x1234. No result_valid after the first beat. result holds 0x1234 until the next completion.
- Beat 0x55 in IDLE, plus req_valid pulsed during COLLECT -> both ignored. The next completion uses only the in-request beats, and req_ready stays 0 until IDLE.
- Mode 10, beat 0xAA, then rst asserted between edges -> result = 0, busy = 0, req_ready = 1 immediately, no result_valid. A subsequent mode 00 load of 0x7F -> 0x007F.
- DATA_WIDTH = 32, BUS_WIDTH = 8: mode 10 with beats 0xEF, 0xBE, 0xAD, 0xDE -> 0xDEADBEEF; mode 01 with beat 0x80 -> 0xFFFFFF80.
